video_layer_mixer: RTL

// - Parametrised compositor for N per-pixel effect-layer intensity streams (dry, delay, reverb, ...) into one HDMI-bound pixel.
// - Aligns layers of differing pipeline latency; applies a per-layer gain latched once per frame; combines layers in a selectable mode.
// - Sits between the layer generators and the GUI overlay on clk_pixel. Replaces the fixed two-layer XOR combine.

---
 rtl/video_pkg.sv | 23 ++
 rtl/mixer_delay_line.sv | 35 +++
 rtl/video_layer_mixer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Types and widths shared by the video layer mixer and its sub-blocks.
// Sync fields travel together as one packed bundle so they are delayed as a unit.
package video_pkg;

    localparam int H_COUNT_W = 11;
    localparam int V_COUNT_W = 10;
    localparam int PIXEL_W   = 24;

    typedef enum logic [1:0] {
        MIX_XOR  = 2'd0,
        MIX_ADD  = 2'd1,
        MIX_MAX  = 2'd2,
        MIX_OVER = 2'd3
    } combine_mode_t;

    typedef struct packed {
        logic [H_COUNT_W-1:0] h_count;
        logic [V_COUNT_W-1:0] v_count;
        logic                 active_draw;
        logic                 new_frame;
    } sync_t;

endpackage

// File: rtl/mixer_delay_line.sv
// Fixed-depth shift register with synchronous reset; DEPTH = 0 is a plain wire.
// Latency: DEPTH cycles.
// Backpressure: none, advances every cycle.
module mixer_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk_pixel,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk_pixel ^ rst;
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clk_pixel) begin
                if (rst) begin
                    for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
                end else begin
                    stage[0] <= din;
                    for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/video_layer_mixer.sv
// Aligns, gain-scales and combines N intensity layers into one pixel (optional tint: VIDEO_MIXER_TINT_EN).
// Latency: ALIGN_DEPTH + 3 cycles (+1 with tint), sync outputs delayed to match.
// Backpressure: none, the pipeline advances every pixel clock.
module video_layer_mixer
    import video_pkg::*;
#(
    parameter int LAYER_COUNT                 = 4,
    parameter int INTENSITY_WIDTH             = 8,
    parameter int GAIN_WIDTH                  = 10,
    parameter int ALIGN_DEPTH                 = 4,
    parameter int LAYER_LATENCY [LAYER_COUNT] = '{default: 0}
) (
    input  logic                                        clk_pixel,
    input  logic                                        rst,
    input  logic [H_COUNT_W-1:0]                        h_count_in,
    input  logic [V_COUNT_W-1:0]                        v_count_in,
    input  logic                                        active_draw_in,
    input  logic                                        new_frame_in,
    input  logic [LAYER_COUNT-1:0][INTENSITY_WIDTH-1:0] layer_intensity,
    input  logic [LAYER_COUNT-1:0][GAIN_WIDTH-1:0]      layer_gain,
    input  logic [1:0]                                  combine_mode,
`ifdef VIDEO_MIXER_TINT_EN
    input  logic [LAYER_COUNT-1:0][PIXEL_W-1:0]         layer_tint,
`endif
    output logic [PIXEL_W-1:0]                          pixel_out,
    output logic [H_COUNT_W-1:0]                        h_count_out,
    output logic [V_COUNT_W-1:0]                        v_count_out,
    output logic                                        active_draw_out,
    output logic                                        new_frame_out
);

    localparam int IW = INTENSITY_WIDTH;
    localparam int GW = GAIN_WIDTH;

    typedef logic [LAYER_COUNT-1:0][IW-1:0] lanes_t;

    // All-ones gain is exact unity rather than (2^GW-1)/2^GW.
    function automatic logic [IW-1:0] scale(input logic [IW-1:0] i, input logic [GW-1:0] g);
        logic [IW+GW-1:0] prod;
        prod  = {{GW{1'b0}}, i} * {{IW{1'b0}}, g};
        scale = (&g) ? i : prod[IW+GW-1:GW];
    endfunction

    function automatic logic [LAYER_COUNT-1:0] nonzero(input lanes_t v);
        logic [LAYER_COUNT-1:0] m;
        m = '0;
        for (int i = 0; i < LAYER_COUNT; i++) m[i] = |v[i];
        nonzero = m;
    endfunction

    // OVER picks by `sel` so tinted lanes still select on their untinted intensity.
    function automatic logic [IW-1:0] combine(input lanes_t v, input logic [LAYER_COUNT-1:0] sel,
                                              input combine_mode_t m);
        logic [IW-1:0] acc_xor, acc_max, acc_over, res;
        logic [IW+3:0] acc_sum;
        acc_xor  = '0;
        acc_max  = '0;
        acc_over = '0;
        acc_sum  = '0;
        for (int i = 0; i < LAYER_COUNT; i++) begin
            acc_xor = acc_xor ^ v[i];
            acc_sum = acc_sum + {4'b0000, v[i]};
            if (v[i] > acc_max) acc_max = v[i];
            if (sel[i]) acc_over = v[i];
        end
        case (m)
            MIX_XOR: res = acc_xor;
            MIX_ADD: res = (|acc_sum[IW+3:IW]) ? '1 : acc_sum[IW-1:0];
            MIX_MAX: res = acc_max;
            default: res = acc_over;
        endcase
        combine = res;
    endfunction

    generate
        if (LAYER_COUNT < 1 || LAYER_COUNT > 8) begin : g_bad_count
            $error("video_layer_mixer: LAYER_COUNT must be 1..8");
        end
        if (3 * IW != PIXEL_W) begin : g_bad_width
            $error("video_layer_mixer: three intensity channels must fill the pixel");
        end
    endgenerate

    // Alignment: sync by ALIGN_DEPTH, each layer by the remainder of its own lag.
    sync_t  sync_in, sync_al;
    lanes_t lay_al;

    assign sync_in = '{h_count: h_count_in, v_count: v_count_in,
                       active_draw: active_draw_in, new_frame: new_frame_in};

    mixer_delay_line #(.WIDTH($bits(sync_t)), .DEPTH(ALIGN_DEPTH)) u_sync_align (
        .clk_pixel (clk_pixel),
        .rst       (rst),
        .din       (sync_in),
        .dout      (sync_al)
    );

    generate
        for (genvar i = 0; i < LAYER_COUNT; i++) begin : g_lane
            if (LAYER_LATENCY[i] < 0 || LAYER_LATENCY[i] > ALIGN_DEPTH) begin : g_bad_lat
                $error("video_layer_mixer: LAYER_LATENCY entry exceeds ALIGN_DEPTH");
            end
            mixer_delay_line #(
                .WIDTH (IW),
                .DEPTH ((LAYER_LATENCY[i] > ALIGN_DEPTH) ? 0 : ALIGN_DEPTH - LAYER_LATENCY[i])
            ) u_lane_align (
                .clk_pixel (clk_pixel),
                .rst       (rst),
                .din       (layer_intensity[i]),
                .dout      (lay_al[i])
            );
        end
    endgenerate

    // Frame-latched settings; the new_frame pixel itself already sees the new values.
    logic [LAYER_COUNT-1:0][GW-1:0] gain_sh, gain_eff;
    combine_mode_t                  mode_sh, mode_eff;
    logic                           live_sh, live_eff;

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            gain_sh <= '0;
            mode_sh <= MIX_XOR;
            live_sh <= 1'b0;
        end else if (sync_al.new_frame) begin
            gain_sh <= layer_gain;
            mode_sh <= combine_mode_t'(combine_mode);
            live_sh <= 1'b1;
        end
    end

    always_comb begin
        gain_eff = sync_al.new_frame ? layer_gain : gain_sh;
        mode_eff = sync_al.new_frame ? combine_mode_t'(combine_mode) : mode_sh;
        live_eff = sync_al.new_frame | live_sh;
    end

    // S1: per-layer gain.
    lanes_t        s1_val;
    sync_t         s1_sync;
    combine_mode_t s1_mode;
    logic          s1_show;

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            s1_val  <= '0;
            s1_sync <= '0;
            s1_mode <= MIX_XOR;
            s1_show <= 1'b0;
        end else begin
            for (int i = 0; i < LAYER_COUNT; i++) s1_val[i] <= scale(lay_al[i], gain_eff[i]);
            s1_sync <= sync_al;
            s1_mode <= mode_eff;
            s1_show <= live_eff & sync_al.active_draw;
        end
    end

    // Combined colour feeding the output register.
    logic [PIXEL_W-1:0] mix_rgb;
    sync_t              mix_sync;
    logic               mix_show;

`ifdef VIDEO_MIXER_TINT_EN
    logic [LAYER_COUNT-1:0][PIXEL_W-1:0] tint_sh, tint_eff, s1_tint;
    lanes_t                              t2 [3];
    logic [LAYER_COUNT-1:0]              s2_sel;
    sync_t                               s2_sync;
    combine_mode_t                       s2_mode;
    logic                                s2_show;

    function automatic logic [IW-1:0] tint_scale(input logic [IW-1:0] s, input logic [7:0] t);
        logic [IW+7:0] prod;
        prod       = {8'h00, s} * {{IW{1'b0}}, t};
        tint_scale = (&t) ? s : prod[IW+7:8];
    endfunction

    always_ff @(posedge clk_pixel) begin
        if (rst) tint_sh <= '0;
        else if (sync_al.new_frame) tint_sh <= layer_tint;
    end

    assign tint_eff = sync_al.new_frame ? layer_tint : tint_sh;

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            s1_tint  <= '0;
            t2       <= '{default: '0};
            s2_sel   <= '0;
            s2_sync  <= '0;
            s2_mode  <= MIX_XOR;
            s2_show  <= 1'b0;
            mix_rgb  <= '0;
            mix_sync <= '0;
            mix_show <= 1'b0;
        end else begin
            s1_tint <= tint_eff;
            for (int ch = 0; ch < 3; ch++) begin
                for (int i = 0; i < LAYER_COUNT; i++) begin
                    t2[ch][i] <= tint_scale(s1_val[i], s1_tint[i][23-8*ch -: 8]);
                end
            end
            s2_sel   <= nonzero(s1_val);
            s2_sync  <= s1_sync;
            s2_mode  <= s1_mode;
            s2_show  <= s1_show;
            mix_rgb  <= {combine(t2[0], s2_sel, s2_mode),
                         combine(t2[1], s2_sel, s2_mode),
                         combine(t2[2], s2_sel, s2_mode)};
            mix_sync <= s2_sync;
            mix_show <= s2_show;
        end
    end
`else
    logic [IW-1:0] grey;

    assign grey = combine(s1_val, nonzero(s1_val), s1_mode);

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            mix_rgb  <= '0;
            mix_sync <= '0;
            mix_show <= 1'b0;
        end else begin
            mix_rgb  <= {grey, grey, grey};
            mix_sync <= s1_sync;
            mix_show <= s1_show;
        end
    end
`endif

    // Output stage: blank outside the visible region or before the first frame.
    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            pixel_out       <= '0;
            h_count_out     <= '0;
            v_count_out     <= '0;
            active_draw_out <= 1'b0;
            new_frame_out   <= 1'b0;
        end else begin
            pixel_out       <= mix_show ? mix_rgb : '0;
            h_count_out     <= mix_sync.h_count;
            v_count_out     <= mix_sync.v_count;
            active_draw_out <= mix_sync.active_draw;
            new_frame_out   <= mix_sync.new_frame;
        end
    end

endmodule
